// File: rtl/branch_resolve_unit.sv
`default_nettype none
// =====================================================================
// Module   : branch_resolve_unit
// Brief    : EX-stage branch resolution. Carries each fetched
//            instruction's BTB prediction through ID and EX, checks it
//            against the real control-flow outcome, drives
//            redirect/flush to fetch, returns a registered update
//            packet to the BTB and keeps saturating branch and
//            mispredict counters.
// Revision : 1.0 - initial release
// =====================================================================
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,                   // asynchronous, active-low
    input  logic            stall,

    // instruction entering ID, with its BTB prediction
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_predicted,
    input  logic [XLEN-1:0] if_predicted_address,

    // actual outcome of the instruction in EX
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,

    // fetch correction
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,

    // BTB training packet
    output logic            btb_update_valid,
    output logic [XLEN-1:0] btb_update_pc,
    output logic [XLEN-1:0] btb_update_target,
    output logic            btb_update_taken,

    // performance counters
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    // -----------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------
    localparam logic [XLEN-1:0]  c_instr_bytes = XLEN'(4);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    // -----------------------------------------------------------------
    // Prediction metadata, ID stage
    // -----------------------------------------------------------------
    logic            r_id_valid;
    logic [XLEN-1:0] r_id_pc;
    logic            r_id_pred;
    logic [XLEN-1:0] r_id_pred_addr;

    // -----------------------------------------------------------------
    // Prediction metadata, EX stage
    // -----------------------------------------------------------------
    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_pc;
    logic            r_ex_pred;
    logic [XLEN-1:0] r_ex_pred_addr;

    // -----------------------------------------------------------------
    // Registered BTB update packet and counters
    // -----------------------------------------------------------------
    logic            r_upd_valid;
    logic [XLEN-1:0] r_upd_pc;
    logic [XLEN-1:0] r_upd_target;
    logic            r_upd_taken;
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispredict_count;

    // -----------------------------------------------------------------
    // Resolution logic
    // -----------------------------------------------------------------
    logic            w_resolve;      // EX holds a live instruction and may retire its outcome
    logic            w_is_ctrl;      // EX instruction is a real control transfer
    logic            w_actual;       // actual taken outcome (jumps are always taken)
    logic [XLEN-1:0] w_seq_pc;       // fall-through address, wraps modulo 2^XLEN
    logic            w_target_wrong; // predicted taken to a different address
    logic            w_mispredict;
    logic            w_redirect;
    logic            w_send_update;

    // Evaluate the EX prediction against the real outcome.
    // A prediction on a non-control instruction (BTB alias) counts as a
    // not-taken outcome that was predicted taken, so it is corrected to
    // the fall-through address and still trains the BTB.
    always_comb begin
        w_resolve      = r_ex_valid & ~stall;
        w_is_ctrl      = ex_is_branch | ex_is_jump;
        w_actual       = ex_is_jump | (ex_is_branch & ex_taken);
        w_seq_pc       = r_ex_pc + c_instr_bytes;
        w_target_wrong = (r_ex_pred_addr != ex_target);
        if (w_actual) begin
            w_mispredict = ~r_ex_pred | w_target_wrong;
        end else begin
            w_mispredict = r_ex_pred;
        end
        w_redirect    = w_resolve & w_mispredict;
        w_send_update = w_resolve & (w_is_ctrl | r_ex_pred);
    end

    // Drive the fetch correction; quiet outside a redirect.
    always_comb begin
        redirect    = w_redirect;
        flush       = w_redirect;
        redirect_pc = '0;
        if (w_redirect) begin
            redirect_pc = w_actual ? ex_target : w_seq_pc;
        end
    end

    // ID stage: capture the incoming instruction, hold on stall, kill on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_id_valid     <= 1'b0;
            r_id_pc        <= '0;
            r_id_pred      <= 1'b0;
            r_id_pred_addr <= '0;
        end else if (!stall) begin
            r_id_valid     <= if_valid & ~w_redirect;
            r_id_pc        <= if_pc;
            r_id_pred      <= if_predicted;
            r_id_pred_addr <= if_predicted_address;
        end
    end

    // EX stage: advance from ID, hold on stall, kill on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_pc        <= '0;
            r_ex_pred      <= 1'b0;
            r_ex_pred_addr <= '0;
        end else if (!stall) begin
            r_ex_valid     <= r_id_valid & ~w_redirect;
            r_ex_pc        <= r_id_pc;
            r_ex_pred      <= r_id_pred;
            r_ex_pred_addr <= r_id_pred_addr;
        end
    end

    // BTB update: strobe for one cycle after each qualifying resolution.
    // The strobe is not gated by stall in the cycle it is presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_upd_valid  <= 1'b0;
            r_upd_pc     <= '0;
            r_upd_target <= '0;
            r_upd_taken  <= 1'b0;
        end else begin
            r_upd_valid <= w_send_update;
            if (w_send_update) begin
                r_upd_pc     <= r_ex_pc;
                r_upd_target <= w_actual ? ex_target : w_seq_pc;
                r_upd_taken  <= w_actual;
            end
        end
    end

    // Resolved control-transfer counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_count <= '0;
        end else if (w_resolve && w_is_ctrl && (r_branch_count != c_cnt_max)) begin
            r_branch_count <= r_branch_count + c_cnt_one;
        end
    end

    // Redirect counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mispredict_count <= '0;
        end else if (w_redirect && (r_mispredict_count != c_cnt_max)) begin
            r_mispredict_count <= r_mispredict_count + c_cnt_one;
        end
    end

    // -----------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------
    assign btb_update_valid  = r_upd_valid;
    assign btb_update_pc     = r_upd_pc;
    assign btb_update_target = r_upd_target;
    assign btb_update_taken  = r_upd_taken;
    assign branch_count      = r_branch_count;
    assign mispredict_count  = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// =====================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Directed self-checking bench for branch_resolve_unit.
//            A second instance with 2-bit counters shares the stimulus
//            to exercise counter saturation.
// Revision : 1.0 - initial release
// =====================================================================
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_predicted;
    logic [31:0] if_predicted_address;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;

    logic        redirect, flush, btb_update_valid, btb_update_taken;
    logic [31:0] redirect_pc, btb_update_pc, btb_update_target;
    logic [15:0] branch_count, mispredict_count;

    logic        s_redirect, s_flush, s_upd_valid, s_upd_taken;
    logic [31:0] s_redirect_pc, s_upd_pc, s_upd_target;
    logic [1:0]  s_branch_count, s_mispredict_count;

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_predicted(if_predicted),
        .if_predicted_address(if_predicted_address),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .btb_update_valid(btb_update_valid), .btb_update_pc(btb_update_pc),
        .btb_update_target(btb_update_target), .btb_update_taken(btb_update_taken),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_resolve_unit #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_predicted(if_predicted),
        .if_predicted_address(if_predicted_address),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .redirect(s_redirect), .redirect_pc(s_redirect_pc), .flush(s_flush),
        .btb_update_valid(s_upd_valid), .btb_update_pc(s_upd_pc),
        .btb_update_target(s_upd_target), .btb_update_taken(s_upd_taken),
        .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into ID, then move it into EX behind a bubble.
    task automatic send(input logic [31:0] pc, input logic pred, input logic [31:0] paddr);
        if_valid = 1'b1; if_pc = pc; if_predicted = pred; if_predicted_address = paddr;
        tick();
        if_valid = 1'b0; if_pc = '0; if_predicted = 1'b0; if_predicted_address = '0;
        tick();
    endtask

    task automatic set_ex(input logic br, input logic jp, input logic tk, input logic [31:0] tgt);
        ex_is_branch = br; ex_is_jump = jp; ex_taken = tk; ex_target = tgt;
        #1;
    endtask

    task automatic clear_ex();
        ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0; ex_target = '0;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0;
        if_valid = 1'b0; if_pc = '0; if_predicted = 1'b0; if_predicted_address = '0;
        clear_ex();
        tick(); tick();
        check_eq("reset_redirect", {31'd0, redirect}, 32'd0);
        check_eq("reset_upd_valid", {31'd0, btb_update_valid}, 32'd0);
        check_eq("reset_upd_pc", btb_update_pc, 32'd0);
        check_eq("reset_branch_cnt", {16'd0, branch_count}, 32'd0);
        check_eq("reset_mispred_cnt", {16'd0, mispredict_count}, 32'd0);
        #2 rst = 1'b1;
        tick();

        // correct taken prediction
        send(32'h100, 1'b1, 32'h200);
        set_ex(1'b1, 1'b0, 1'b1, 32'h200);
        check_eq("t1_redirect", {31'd0, redirect}, 32'd0);
        check_eq("t1_flush", {31'd0, flush}, 32'd0);
        check_eq("t1_redirect_pc", redirect_pc, 32'd0);
        tick(); clear_ex();
        check_eq("t1_upd_valid", {31'd0, btb_update_valid}, 32'd1);
        check_eq("t1_upd_pc", btb_update_pc, 32'h100);
        check_eq("t1_upd_target", btb_update_target, 32'h200);
        check_eq("t1_upd_taken", {31'd0, btb_update_taken}, 32'd1);
        check_eq("t1_branch_cnt", {16'd0, branch_count}, 32'd1);
        check_eq("t1_mispred_cnt", {16'd0, mispredict_count}, 32'd0);
        tick();
        check_eq("t1_upd_pulse_end", {31'd0, btb_update_valid}, 32'd0);

        // predicted taken, not taken; younger ID/IF instructions must die
        if_valid = 1'b1; if_pc = 32'h104; if_predicted = 1'b1; if_predicted_address = 32'h200;
        tick();
        if_pc = 32'h108; if_predicted = 1'b0; if_predicted_address = 32'h0;
        tick();
        if_pc = 32'h10C; if_predicted = 1'b1; if_predicted_address = 32'h400;
        set_ex(1'b1, 1'b0, 1'b0, 32'h300);
        check_eq("t2_redirect", {31'd0, redirect}, 32'd1);
        check_eq("t2_redirect_pc", redirect_pc, 32'h108);
        check_eq("t2_flush", {31'd0, flush}, 32'd1);
        tick();
        if_valid = 1'b0; if_pc = '0; if_predicted = 1'b0; if_predicted_address = '0;
        check_eq("t2_upd_valid", {31'd0, btb_update_valid}, 32'd1);
        check_eq("t2_upd_pc", btb_update_pc, 32'h104);
        check_eq("t2_upd_taken", {31'd0, btb_update_taken}, 32'd0);
        check_eq("t2_upd_target", btb_update_target, 32'h108);
        check_eq("t2_mispred_cnt", {16'd0, mispredict_count}, 32'd1);
        check_eq("t2_branch_cnt", {16'd0, branch_count}, 32'd2);
        // a jump in EX would mispredict if EX were live; killed stages must stay silent
        set_ex(1'b0, 1'b1, 1'b0, 32'h500);
        check_eq("t2_ex_killed", {31'd0, redirect}, 32'd0);
        tick();
        check_eq("t2_no_upd_after_kill", {31'd0, btb_update_valid}, 32'd0);
        check_eq("t2_id_killed", {31'd0, redirect}, 32'd0);
        tick();
        check_eq("t2_branch_cnt_hold", {16'd0, branch_count}, 32'd2);
        clear_ex();

        // JALR with wrong predicted target
        send(32'h40, 1'b1, 32'h80);
        set_ex(1'b0, 1'b1, 1'b0, 32'h90);
        check_eq("t3a_redirect", {31'd0, redirect}, 32'd1);
        check_eq("t3a_redirect_pc", redirect_pc, 32'h90);
        tick(); clear_ex();
        check_eq("t3a_upd_target", btb_update_target, 32'h90);
        check_eq("t3a_upd_taken", {31'd0, btb_update_taken}, 32'd1);
        check_eq("t3a_branch_cnt", {16'd0, branch_count}, 32'd3);

        // aliased prediction on a non-branch
        send(32'h44, 1'b1, 32'h60);
        set_ex(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("t3b_redirect", {31'd0, redirect}, 32'd1);
        check_eq("t3b_redirect_pc", redirect_pc, 32'h48);
        tick(); clear_ex();
        check_eq("t3b_upd_valid", {31'd0, btb_update_valid}, 32'd1);
        check_eq("t3b_upd_pc", btb_update_pc, 32'h44);
        check_eq("t3b_upd_taken", {31'd0, btb_update_taken}, 32'd0);
        check_eq("t3b_upd_target", btb_update_target, 32'h48);
        check_eq("t3b_branch_cnt", {16'd0, branch_count}, 32'd3);
        check_eq("t3b_mispred_cnt", {16'd0, mispredict_count}, 32'd3);
        check_eq("t3b_sat_mispred", {30'd0, s_mispredict_count}, 32'd3);
        check_eq("t3b_sat_branch", {30'd0, s_branch_count}, 32'd3);

        // mispredicting jump held in EX by stall
        send(32'h200, 1'b0, 32'h0);
        stall = 1'b1;
        set_ex(1'b0, 1'b1, 1'b0, 32'h300);
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_stall_redirect", {31'd0, redirect}, 32'd0);
            tick();
            check_eq("t4_stall_upd", {31'd0, btb_update_valid}, 32'd0);
            check_eq("t4_stall_mispred", {16'd0, mispredict_count}, 32'd3);
        end
        stall = 1'b0;
        #1;
        check_eq("t4_release_redirect", {31'd0, redirect}, 32'd1);
        check_eq("t4_release_pc", redirect_pc, 32'h300);
        tick(); clear_ex();
        check_eq("t4_upd_valid", {31'd0, btb_update_valid}, 32'd1);
        check_eq("t4_upd_pc", btb_update_pc, 32'h200);
        check_eq("t4_mispred_cnt", {16'd0, mispredict_count}, 32'd4);
        check_eq("t4_branch_cnt", {16'd0, branch_count}, 32'd4);
        check_eq("t4_sat_mispred", {30'd0, s_mispredict_count}, 32'd3);
        check_eq("t4_no_second_redirect", {31'd0, redirect}, 32'd0);
        tick();
        check_eq("t4_upd_pulse_end", {31'd0, btb_update_valid}, 32'd0);

        // PC wrap on fall-through correction
        send(32'hFFFF_FFFC, 1'b1, 32'h10);
        set_ex(1'b1, 1'b0, 1'b0, 32'h10);
        check_eq("t5_redirect", {31'd0, redirect}, 32'd1);
        check_eq("t5_redirect_pc", redirect_pc, 32'h0);
        tick(); clear_ex();
        check_eq("t5_upd_target", btb_update_target, 32'h0);
        check_eq("t5_mispred_cnt", {16'd0, mispredict_count}, 32'd5);
        check_eq("t5_sat_mispred", {30'd0, s_mispredict_count}, 32'd3);
        check_eq("t5_sat_branch", {30'd0, s_branch_count}, 32'd3);

        // branch and jump both set: treated as taken jump, prediction correct
        send(32'h300, 1'b1, 32'h340);
        set_ex(1'b1, 1'b1, 1'b0, 32'h340);
        check_eq("t6_redirect", {31'd0, redirect}, 32'd0);
        tick(); clear_ex();
        check_eq("t6_upd_taken", {31'd0, btb_update_taken}, 32'd1);
        check_eq("t6_upd_target", btb_update_target, 32'h340);
        check_eq("t6_branch_cnt", {16'd0, branch_count}, 32'd6);

        // asynchronous reset in the cycle after a redirect
        send(32'h500, 1'b0, 32'h0);
        set_ex(1'b0, 1'b1, 1'b0, 32'h600);
        check_eq("t7_redirect", {31'd0, redirect}, 32'd1);
        tick(); clear_ex();
        check_eq("t7_upd_before_rst", {31'd0, btb_update_valid}, 32'd1);
        check_eq("t7_mispred_before_rst", {16'd0, mispredict_count}, 32'd6);
        #2 rst = 1'b0;
        #1;
        check_eq("t7_rst_upd_valid", {31'd0, btb_update_valid}, 32'd0);
        check_eq("t7_rst_upd_pc", btb_update_pc, 32'h0);
        check_eq("t7_rst_branch_cnt", {16'd0, branch_count}, 32'd0);
        check_eq("t7_rst_mispred_cnt", {16'd0, mispredict_count}, 32'd0);
        check_eq("t7_rst_sat_mispred", {30'd0, s_mispredict_count}, 32'd0);
        // clocks under reset must not load the pipe
        if_valid = 1'b1; if_pc = 32'h900; if_predicted = 1'b1; if_predicted_address = 32'h980;
        set_ex(1'b0, 1'b1, 1'b0, 32'hA00);
        tick(); tick(); tick();
        check_eq("t7_hold_redirect", {31'd0, redirect}, 32'd0);
        check_eq("t7_hold_upd_valid", {31'd0, btb_update_valid}, 32'd0);
        check_eq("t7_hold_id_valid", {31'd0, dut.r_id_valid}, 32'd0);
        check_eq("t7_hold_ex_valid", {31'd0, dut.r_ex_valid}, 32'd0);
        if_valid = 1'b0; clear_ex();
        #2 rst = 1'b1;
        tick();
        check_eq("t7_after_release_cnt", {16'd0, branch_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage counterpart to the IF-stage branch target buffer.
- Carries each fetched instruction's prediction (predicted, predicted_address) through ID to EX.
- In EX, compares the prediction with the actual control-flow outcome and drives redirect/flush to the fetch unit.
- Sends a registered one-cycle update packet back to the BTB and keeps saturating branch/mispredict counters.

Parameters:
- XLEN, 32, address/PC width
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- stall  input  1  pipeline hold; freezes metadata pipe, blocks resolution
- if_valid  input  1  an instruction enters ID this cycle
- if_pc  input  XLEN  PC of that instruction
- if_predicted  input  1  BTB predicted taken for that instruction
- if_predicted_address  input  XLEN  BTB predicted target
- ex_is_branch  input  1  EX instruction is a conditional branch
- ex_is_jump  input  1  EX instruction is JAL/JALR
- ex_taken  input  1  branch condition true (ignored unless ex_is_branch)
- ex_target  input  XLEN  computed target of EX branch/jump
- redirect  output  1  combinational: fetch must load redirect_pc this cycle
- redirect_pc  output  XLEN  corrected fetch address
- flush  output  1  combinational, equals redirect: kill IF and ID contents
- btb_update_valid  output  1  registered one-cycle update strobe
- btb_update_pc  output  XLEN  PC of the resolved instruction
- btb_update_target  output  XLEN  resolved target
- btb_update_taken  output  1  actual outcome
- branch_count  output  CNT_W  resolved control-transfer instructions
- mispredict_count  output  CNT_W  redirects issued

Behaviour:
- Reset (rst low, asynchronous):
  - id_meta.valid = 0 and ex_meta.valid = 0; all stored fields = 0.
  - btb_update_* = 0, both counters = 0.
  - redirect = 0 while reset is held.
- Metadata pipe, stages ID and EX, each {valid, pc, pred, pred_addr}:
  - stall = 1: both stages hold their contents.
  - stall = 0, redirect = 0: ID <= IF inputs (valid = if_valid); EX <= ID.
  - stall = 0, redirect = 1: ID.valid <= 0 and EX.valid <= 0. Both younger instructions are killed.
- Resolution happens when ex_meta.valid = 1 and stall = 0. Let actual = ex_is_jump | (ex_is_branch & ex_taken).
  - actual = 1 and (pred = 0 or pred_addr != ex_target): redirect to ex_target.
  - actual = 0 and pred = 1: redirect to ex_meta.pc + 4, modulo 2^XLEN.
  - This covers aliased predictions on non-control-transfer instructions.
  - Otherwise: no redirect.
- Outside resolution, redirect = 0 and redirect_pc = 0.
- BTB update, registered one cycle after resolution; btb_update_valid is high for exactly one cycle:
  - Sent for every resolution where ex_is_branch | ex_is_jump | pred.
  - Fields: pc = ex_meta.pc; taken = actual; target = actual ? ex_target : ex_meta.pc + 4.
  - btb_update_valid is independent of stall in the following cycle.
- Counters:
  - branch_count increments on each resolution with ex_is_branch | ex_is_jump.
  - mispredict_count increments on each redirect.
  - Both saturate at 2^CNT_W - 1; no wrap.
  - Both increment in the same edge when applicable.
- ex_is_branch and ex_is_jump both high: treat as a jump (actual = 1).
- Reset asserted mid-operation: all state clears immediately; a pending btb_update_valid pulse is dropped.

Test Plan:
- Correct taken prediction:
  - Stimulus: pc 0x100, pred = 1, pred_addr 0x200; in EX ex_is_branch = 1, ex_taken = 1, ex_target 0x200.
  - Required: redirect = 0. Next cycle btb_update_valid = 1 with pc 0x100, target 0x200, taken = 1. branch_count = 1, mispredict_count = 0.
- Predicted taken, actually not taken:
  - Stimulus: pc 0x104, pred = 1, ex_taken = 0.
  - Required: redirect = 1, redirect_pc 0x108, flush = 1. Following cycle ID.valid = 0 and EX.valid = 0. Update has taken = 0, target 0x108. mispredict_count = 1.
- Wrong target and aliasing:
  - Stimulus 1: JALR at 0x40, pred_addr 0x80, ex_target 0x90.
  - Required: redirect_pc 0x90.
  - Stimulus 2: non-branch at 0x44 with pred = 1.
  - Required: redirect_pc 0x48, update taken = 0, branch_count unchanged.
- Stall hold:
  - Stimulus: a mispredicting instruction in EX with stall = 1 for 3 cycles.
  - Required: no redirect and no counter change during the stall. On the first cycle with stall = 0: exactly one redirect, and one update pulse the cycle after.
- Saturation and PC wrap:
  - Stimulus: CNT_W = 2 with 5 mispredicts.
  - Required: mispredict_count = 3.
  - Stimulus: pc 0xFFFFFFFC predicted taken but not taken.
  - Required: redirect_pc 0x00000000.
- Asynchronous reset:
  - Stimulus: assert rst low between clock edges in the cycle after a redirect.
  - Required: btb_update_valid, counters and valid bits go to 0 immediately, without waiting for a clock edge.
